pbvi_loop_ctrl: RTL and testbench

PBVI_LOOP_CTRL -- requirements
Module: pbvi_loop_ctrl

---
 rtl/pbvi_loop_ctrl_if.sv | 29 ++
 rtl/pbvi_loop_ctrl.sv | 128 ++++++++++++
 tb/tb_pbvi_loop_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pbvi_loop_ctrl_if.sv
// pbvi_loop_ctrl_if: run-control, alpha-vector and backup-pipeline handshake bundle.
interface pbvi_loop_ctrl_if #(
    parameter int N_POINT = 16
);
    logic                               start;
    logic [7:0]                         max_iter;
    logic [15:0]                        epsilon;
    logic [N_POINT-1:0][1:0][15:0]      alpha_init;
    logic                               en_loop;
    logic [N_POINT-1:0][1:0][15:0]      alpha_new;
    logic [N_POINT-1:0][1:0]            point_action;
    logic                               en_step;
    logic [N_POINT-1:0][1:0][15:0]      alpha_cur;
    logic [N_POINT-1:0][1:0]            policy;
    logic [7:0]                         iter_count;
    logic [15:0]                        max_diff;
    logic                               done;
    logic [1:0]                         status;

    modport master (
        output start, max_iter, epsilon, alpha_init, en_loop, alpha_new, point_action,
        input  en_step, alpha_cur, policy, iter_count, max_diff, done, status
    );

    modport slave (
        input  start, max_iter, epsilon, alpha_init, en_loop, alpha_new, point_action,
        output en_step, alpha_cur, policy, iter_count, max_diff, done, status
    );
endinterface

// File: rtl/pbvi_loop_ctrl.sv
// pbvi_loop_ctrl: PBVI value-iteration loop controller; launches backup passes,
// compares successive alpha sets one point per cycle and stops on convergence, limit or timeout.
module pbvi_loop_ctrl #(
    parameter int N_POINT = 16,
    parameter int TIMEOUT = 1024
) (
    input logic             clk,
    input logic             rst_n,
    pbvi_loop_ctrl_if.slave bus
);
    localparam int IW = (N_POINT > 1) ? $clog2(N_POINT) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CMP, UPDATE, DONE} state_t;
    typedef logic [N_POINT-1:0][1:0][15:0] avec_t;

    state_t                  state_q, state_d;
    avec_t                   alpha_cur_q, alpha_cur_d;
    avec_t                   alpha_nxt_q, alpha_nxt_d;
    logic [N_POINT-1:0][1:0] policy_q, policy_d;
    logic [7:0]              iter_q, iter_d;
    logic [15:0]             max_diff_q, max_diff_d;
    logic [1:0]              status_q, status_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [WW-1:0]           wait_q, wait_d;
    logic [15:0]             run_max_q, run_max_d;

    logic [16:0] diff0, diff1;
    logic [15:0] abs0, abs1, pt_max, cmp_max;
    logic [7:0]  iter_inc, limit;
    logic        limit_hit;

    // 17-bit differences so the magnitude never wraps, even for 0xFFFF vs 0x0000
    assign diff0     = {1'b0, alpha_nxt_q[idx_q][0]} - {1'b0, alpha_cur_q[idx_q][0]};
    assign diff1     = {1'b0, alpha_nxt_q[idx_q][1]} - {1'b0, alpha_cur_q[idx_q][1]};
    assign abs0      = diff0[16] ? 16'(~diff0 + 17'd1) : diff0[15:0];
    assign abs1      = diff1[16] ? 16'(~diff1 + 17'd1) : diff1[15:0];
    assign pt_max    = (abs0 > abs1) ? abs0 : abs1;
    assign cmp_max   = (run_max_q > pt_max) ? run_max_q : pt_max;
    assign iter_inc  = (iter_q == 8'hFF) ? iter_q : iter_q + 8'd1;
    assign limit     = (bus.max_iter == 8'd0) ? 8'd1 : bus.max_iter;
    assign limit_hit = ({1'b0, iter_q} + 9'd1) >= {1'b0, limit};

    always_comb begin
        state_d     = state_q;
        alpha_cur_d = alpha_cur_q;
        alpha_nxt_d = alpha_nxt_q;
        policy_d    = policy_q;
        iter_d      = iter_q;
        max_diff_d  = max_diff_q;
        status_d    = status_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        run_max_d   = run_max_q;
        case (state_q)
            IDLE, DONE: if (bus.start) begin
                alpha_cur_d = bus.alpha_init;
                iter_d      = '0;
                max_diff_d  = '0;
                status_d    = 2'b00;
                state_d     = LAUNCH;
            end
            LAUNCH: begin
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: if (bus.en_loop) begin
                alpha_nxt_d = bus.alpha_new;
                policy_d    = bus.point_action;
                idx_d       = '0;
                run_max_d   = '0;
                state_d     = CMP;
            end else if (wait_q == WW'(TIMEOUT - 1)) begin
                status_d = 2'b11;
                state_d  = DONE;
            end else begin
                wait_d = wait_q + 1'b1;
            end
            CMP: begin
                run_max_d = cmp_max;
                idx_d     = idx_q + 1'b1;
                state_d   = (idx_q == IW'(N_POINT - 1)) ? UPDATE : CMP;
            end
            UPDATE: begin
                alpha_cur_d = alpha_nxt_q;
                iter_d      = iter_inc;
                max_diff_d  = run_max_q;
                status_d    = (run_max_q <= bus.epsilon) ? 2'b01 : limit_hit ? 2'b10 : 2'b00;
                state_d     = (run_max_q <= bus.epsilon || limit_hit) ? DONE : LAUNCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alpha_cur_q <= '0;
            alpha_nxt_q <= '0;
            policy_q    <= '0;
            iter_q      <= '0;
            max_diff_q  <= '0;
            status_q    <= '0;
            idx_q       <= '0;
            wait_q      <= '0;
            run_max_q   <= '0;
        end else begin
            state_q     <= state_d;
            alpha_cur_q <= alpha_cur_d;
            alpha_nxt_q <= alpha_nxt_d;
            policy_q    <= policy_d;
            iter_q      <= iter_d;
            max_diff_q  <= max_diff_d;
            status_q    <= status_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            run_max_q   <= run_max_d;
        end
    end

    assign bus.en_step    = (state_q == LAUNCH);
    assign bus.done       = (state_q == DONE);
    assign bus.alpha_cur  = alpha_cur_q;
    assign bus.policy     = policy_q;
    assign bus.iter_count = iter_q;
    assign bus.max_diff   = max_diff_q;
    assign bus.status     = status_q;
endmodule

// File: tb/tb_pbvi_loop_ctrl.sv
// tb_pbvi_loop_ctrl: directed bench for pbvi_loop_ctrl; the bench plays the backup pipeline.
module tb_pbvi_loop_ctrl;
    localparam int N  = 16;
    localparam int TO = 1024;
    typedef logic [N-1:0][1:0][15:0] avec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pbvi_loop_ctrl_if #(.N_POINT(N)) bus ();
    pbvi_loop_ctrl #(.N_POINT(N), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail = 0;
    int steps = 0;
    int lat;
    avec_t a, b;

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.en_step) steps++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic avec_t fill(input logic [15:0] v);
        avec_t r;
        for (int i = 0; i < N; i++) begin
            r[i][0] = v;
            r[i][1] = v;
        end
        return r;
    endfunction

    task automatic chk_alpha(input string tag, input avec_t exp);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s[%0d]", tag, i), {bus.alpha_cur[i][1], bus.alpha_cur[i][0]}, {exp[i][1], exp[i][0]});
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " done"}, 32'(bus.done), 32'd0);
        chk({tag, " status"}, 32'(bus.status), 32'd0);
        chk({tag, " iter"}, 32'(bus.iter_count), 32'd0);
        chk({tag, " max_diff"}, 32'(bus.max_diff), 32'd0);
        chk({tag, " en_step"}, 32'(bus.en_step), 32'd0);
        chk({tag, " policy"}, 32'(bus.policy), 32'd0);
        chk_alpha({tag, " alpha"}, '0);
    endtask

    // leaves the DUT in LAUNCH, sampled #1 after the edge
    task automatic start_run(input avec_t init, input logic [7:0] mi, input logic [15:0] eps);
        bus.alpha_init = init;
        bus.max_iter   = mi;
        bus.epsilon    = eps;
        bus.start      = 1'b1;
        steps          = 0;
        tick();
        bus.start = 1'b0;
        chk("launch en_step", 32'(bus.en_step), 32'd1);
    endtask

    // one backup pass; lat counts cycles from the en_loop edge to the next en_step or done
    task automatic pass(input avec_t nxt, input logic [31:0] act, output int l);
        tick();
        bus.alpha_new    = nxt;
        bus.point_action = act;
        bus.en_loop      = 1'b1;
        tick();
        bus.en_loop = 1'b0;
        l = 1;
        while (!bus.en_step && !bus.done && l < 100) begin
            tick();
            l++;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.max_iter = '0;
        bus.epsilon = '0;
        bus.alpha_init = '0;
        bus.en_loop = 1'b0;
        bus.alpha_new = '0;
        bus.point_action = '0;
        tick();
        tick();
        chk_idle("reset");
        rst_n = 1'b1;
        tick();

        // single converging pass
        start_run(fill(16'h1000), 8'd5, 16'h0010);
        chk_alpha("conv init", fill(16'h1000));
        pass(fill(16'h1008), 32'hA5A5_1234, lat);
        chk("conv latency", 32'(lat), 32'd18);
        chk("conv done", 32'(bus.done), 32'd1);
        chk("conv status", 32'(bus.status), 32'd1);
        chk("conv iter", 32'(bus.iter_count), 32'd1);
        chk("conv max_diff", 32'(bus.max_diff), 32'h0008);
        chk("conv policy", 32'(bus.policy), 32'hA5A5_1234);
        chk("conv steps", 32'(steps), 32'd1);
        chk_alpha("conv alpha", fill(16'h1008));
        bus.alpha_new = fill(16'h5555);
        bus.point_action = 32'h0;
        bus.en_loop = 1'b1;
        tick();
        bus.en_loop = 1'b0;
        repeat (4) tick();
        chk("hold done", 32'(bus.done), 32'd1);
        chk("hold status", 32'(bus.status), 32'd1);
        chk("hold iter", 32'(bus.iter_count), 32'd1);
        chk("hold policy", 32'(bus.policy), 32'hA5A5_1234);
        chk("hold steps", 32'(steps), 32'd1);
        chk_alpha("hold alpha", fill(16'h1008));

        // iteration limit
        start_run(fill(16'h0200), 8'd3, 16'h0000);
        for (int p = 0; p < 3; p++) begin
            pass(fill(16'(16'h0200 + 16'h0100 * (p + 1))), 32'(p + 1), lat);
            chk($sformatf("lim latency %0d", p), 32'(lat), 32'd18);
            chk($sformatf("lim done %0d", p), 32'(bus.done), 32'(p == 2));
        end
        chk("lim status", 32'(bus.status), 32'd2);
        chk("lim iter", 32'(bus.iter_count), 32'd3);
        chk("lim max_diff", 32'(bus.max_diff), 32'h0100);
        chk("lim steps", 32'(steps), 32'd3);
        chk("lim policy", 32'(bus.policy), 32'd3);
        chk_alpha("lim alpha", fill(16'h0500));

        // timeout: never answer the launch
        for (int i = 0; i < N; i++) begin
            a[i][0] = 16'(16'h0A00 + 2 * i);
            a[i][1] = 16'(16'h0A01 + 2 * i);
        end
        start_run(a, 8'd4, 16'h0000);
        lat = 0;
        while (!bus.done && lat < 2000) begin
            tick();
            lat++;
        end
        chk("to latency", 32'(lat), 32'(TO + 1));
        chk("to status", 32'(bus.status), 32'd3);
        chk("to iter", 32'(bus.iter_count), 32'd0);
        chk("to max_diff", 32'(bus.max_diff), 32'd0);
        chk("to steps", 32'(steps), 32'd1);
        chk_alpha("to alpha", a);

        // abs-diff boundary, cur above nxt; equal to epsilon counts as converged
        a = fill(16'h1234);
        a[15][1] = 16'hFFFF;
        b = fill(16'h1234);
        b[15][1] = 16'h0000;
        start_run(a, 8'd1, 16'hFFFF);
        pass(b, 32'h0, lat);
        chk("abs1 latency", 32'(lat), 32'd18);
        chk("abs1 status", 32'(bus.status), 32'd1);
        chk("abs1 max_diff", 32'(bus.max_diff), 32'hFFFF);
        chk("abs1 iter", 32'(bus.iter_count), 32'd1);

        // abs-diff boundary, nxt above cur; just over epsilon hits the limit
        a = fill(16'h0000);
        b = fill(16'h0000);
        b[0][0] = 16'hFFFF;
        start_run(a, 8'd1, 16'hFFFE);
        pass(b, 32'h0, lat);
        chk("abs2 status", 32'(bus.status), 32'd2);
        chk("abs2 max_diff", 32'(bus.max_diff), 32'hFFFF);

        // reset in the middle of the comparison (idx 7)
        start_run(fill(16'h3000), 8'd5, 16'h0000);
        tick();
        bus.alpha_new = fill(16'h3100);
        bus.point_action = 32'hFFFF_0000;
        bus.en_loop = 1'b1;
        tick();
        bus.en_loop = 1'b0;
        repeat (7) tick();
        chk("mid done", 32'(bus.done), 32'd0);
        rst_n = 1'b0;
        bus.en_loop = 1'b1;
        tick();
        chk_idle("midrst");
        rst_n = 1'b1;
        tick();
        bus.en_loop = 1'b0;
        steps = 0;
        repeat (5) tick();
        chk("stray steps", 32'(steps), 32'd0);
        chk("stray done", 32'(bus.done), 32'd0);
        chk("stray policy", 32'(bus.policy), 32'd0);
        chk("stray status", 32'(bus.status), 32'd0);

        // max_iter 0 acts as 1; start while waiting is ignored
        start_run(fill(16'h0100), 8'd0, 16'h0000);
        tick();
        bus.start = 1'b1;
        bus.alpha_init = fill(16'h7777);
        tick();
        tick();
        bus.start = 1'b0;
        chk("wstart en_step", 32'(bus.en_step), 32'd0);
        pass(fill(16'h0105), 32'h1234_5678, lat);
        chk("mi0 latency", 32'(lat), 32'd18);
        chk("mi0 status", 32'(bus.status), 32'd2);
        chk("mi0 iter", 32'(bus.iter_count), 32'd1);
        chk("mi0 max_diff", 32'(bus.max_diff), 32'h0005);
        chk("mi0 steps", 32'(steps), 32'd1);
        chk_alpha("mi0 alpha", fill(16'h0105));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
